phys_reg_free_list: RTL and testbench

Circular FIFO of free physical register tags for the OoO core's rename stage. It hands a free tag to dispatch for every register-writing instruction and takes back tags freed by the ROB on commit (safe tag) or revert (speculated tag). It keeps one saved head pointer per checkpoint column, so a branch-mispredict restore returns every tag allocated after the checkpoint in one cycle. It sits between dispatch/rename and the ROB, alongside the phys reg map table.

---
 rtl/phys_reg_free_list_pkg.sv | 17 +
 rtl/phys_reg_free_list.sv | 86 ++++++++
 tb/tb_phys_reg_free_list.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing constants and types for the rename-stage physical register free list.
// Pointers carry one extra wrap bit above the index so full and empty are distinguishable.
package phys_reg_free_list_pkg;

    localparam int FREE_LIST_DEPTH        = 32;
    localparam int LOG_FREE_LIST_DEPTH    = $clog2(FREE_LIST_DEPTH);
    localparam int NUM_ARCH_REGS          = 32;
    localparam int NUM_PHYS_REGS          = NUM_ARCH_REGS + FREE_LIST_DEPTH;
    localparam int LOG_PHYS_REGS          = $clog2(NUM_PHYS_REGS);
    localparam int CHECKPOINT_COLUMNS     = 4;
    localparam int LOG_CHECKPOINT_COLUMNS = $clog2(CHECKPOINT_COLUMNS);

    typedef logic [LOG_PHYS_REGS-1:0]          phys_reg_tag_t;
    typedef logic [LOG_FREE_LIST_DEPTH:0]      free_list_ptr_t;
    typedef logic [LOG_CHECKPOINT_COLUMNS-1:0] checkpoint_column_t;

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags with per-checkpoint saved head pointers,
// so a mispredict restore hands back every tag allocated since the checkpoint in one cycle.
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    output logic               dequeue_valid,
    output phys_reg_tag_t      dequeue_phys_reg_tag,
    input  logic               dequeue_ready,
    input  logic               enqueue_valid,
    input  phys_reg_tag_t      enqueue_phys_reg_tag,
    input  logic               save_checkpoint_valid,
    input  checkpoint_column_t save_checkpoint_column,
    input  logic               restore_checkpoint_valid,
    input  checkpoint_column_t restore_checkpoint_column,
    output free_list_ptr_t     free_count
);

    phys_reg_tag_t  entry_q [FREE_LIST_DEPTH];
    phys_reg_tag_t  entry_d [FREE_LIST_DEPTH];
    free_list_ptr_t ckpt_q  [CHECKPOINT_COLUMNS];
    free_list_ptr_t ckpt_d  [CHECKPOINT_COLUMNS];
    free_list_ptr_t head_q, head_d;
    free_list_ptr_t tail_q, tail_d;
    free_list_ptr_t head_after_deq;

    logic list_full;
    logic deq_fire;
    logic enq_fire;

    assign free_count           = tail_q - head_q;
    assign list_full            = (free_count == free_list_ptr_t'(FREE_LIST_DEPTH));
    assign dequeue_valid        = (free_count != '0) && !restore_checkpoint_valid;
    assign dequeue_phys_reg_tag = entry_q[head_q[LOG_FREE_LIST_DEPTH-1:0]];
    assign deq_fire             = dequeue_valid && dequeue_ready;
    // A full list can still accept a tag when the head slot is being freed this cycle.
    assign enq_fire             = enqueue_valid && (!list_full || deq_fire);

    always_comb begin
        head_after_deq = deq_fire ? head_q + free_list_ptr_t'(1) : head_q;
        head_d         = head_after_deq;
        tail_d         = tail_q;
        entry_d        = entry_q;
        ckpt_d         = ckpt_q;

        if (restore_checkpoint_valid) begin
            head_d = ckpt_q[restore_checkpoint_column];
        end else if (save_checkpoint_valid) begin
            ckpt_d[save_checkpoint_column] = head_after_deq;
        end

        if (enq_fire) begin
            entry_d[tail_q[LOG_FREE_LIST_DEPTH-1:0]] = enqueue_phys_reg_tag;
            tail_d = tail_q + free_list_ptr_t'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
                entry_q[i] <= phys_reg_tag_t'(NUM_ARCH_REGS + i);
            end
            for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
                ckpt_q[c] <= '0;
            end
            head_q <= '0;
            tail_q <= free_list_ptr_t'(FREE_LIST_DEPTH);
        end else begin
            entry_q <= entry_d;
            ckpt_q  <= ckpt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Overfilling is tolerated (dropped) but worth a trace; save+restore together is a caller bug.
    a_no_enqueue_when_full: assert property (@(posedge CLK) disable iff (!nRST)
        !(enqueue_valid && list_full && !deq_fire))
        else $warning("free list: enqueue while full was dropped");

    a_no_save_on_restore: assert property (@(posedge CLK) disable iff (!nRST)
        !(save_checkpoint_valid && restore_checkpoint_valid))
        else $error("free list: checkpoint save coincided with restore");

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench: a queue model of free tags plus a list of tags handed out since reset,
// so checkpoints are just positions in that list.
module tb_phys_reg_free_list;
    import phys_reg_free_list_pkg::*;

    logic               CLK = 1'b0;
    logic               nRST;
    logic               dequeue_valid;
    phys_reg_tag_t      dequeue_phys_reg_tag;
    logic               dequeue_ready;
    logic               enqueue_valid;
    phys_reg_tag_t      enqueue_phys_reg_tag;
    logic               save_checkpoint_valid;
    checkpoint_column_t save_checkpoint_column;
    logic               restore_checkpoint_valid;
    checkpoint_column_t restore_checkpoint_column;
    free_list_ptr_t     free_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int taken[$];
    int ckpt[CHECKPOINT_COLUMNS];

    phys_reg_free_list dut (
        .CLK                       (CLK),
        .nRST                      (nRST),
        .dequeue_valid             (dequeue_valid),
        .dequeue_phys_reg_tag      (dequeue_phys_reg_tag),
        .dequeue_ready             (dequeue_ready),
        .enqueue_valid             (enqueue_valid),
        .enqueue_phys_reg_tag      (enqueue_phys_reg_tag),
        .save_checkpoint_valid     (save_checkpoint_valid),
        .save_checkpoint_column    (save_checkpoint_column),
        .restore_checkpoint_valid  (restore_checkpoint_valid),
        .restore_checkpoint_column (restore_checkpoint_column),
        .free_count                (free_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        taken.delete();
        for (int i = 0; i < FREE_LIST_DEPTH; i++) exp_q.push_back(NUM_ARCH_REGS + i);
        for (int c = 0; c < CHECKPOINT_COLUMNS; c++) ckpt[c] = 0;
    endtask

    task automatic drive_idle();
        dequeue_ready             = 1'b0;
        enqueue_valid             = 1'b0;
        enqueue_phys_reg_tag      = '0;
        save_checkpoint_valid     = 1'b0;
        save_checkpoint_column    = '0;
        restore_checkpoint_valid  = 1'b0;
        restore_checkpoint_column = '0;
    endtask

    // Reset lands mid-cycle so the asynchronous path is what gets observed.
    task automatic do_reset();
        @(negedge CLK);
        drive_idle();
        #2;
        nRST = 1'b0;
        #1;
        chk("rst_free_count", free_count, FREE_LIST_DEPTH);
        chk("rst_dequeue_valid", dequeue_valid, 1);
        chk("rst_dequeue_tag", dequeue_phys_reg_tag, NUM_ARCH_REGS);
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic step(input bit deq, input bit enq, input int etag,
                        input bit sv, input int scol, input bit rs, input int rcol);
        int pre;
        int exp_tag;
        bit vexp;
        bit fire;
        @(negedge CLK);
        dequeue_ready             = deq;
        enqueue_valid             = enq;
        enqueue_phys_reg_tag      = etag[5:0];
        save_checkpoint_valid     = sv;
        save_checkpoint_column    = scol[1:0];
        restore_checkpoint_valid  = rs;
        restore_checkpoint_column = rcol[1:0];
        #1;
        pre  = exp_q.size();
        vexp = (pre != 0) && !rs;
        fire = vexp && deq;
        chk("free_count", free_count, pre);
        chk("dequeue_valid", dequeue_valid, vexp);
        if (fire) begin
            exp_tag = exp_q.pop_front();
            chk("dequeue_tag", dequeue_phys_reg_tag, exp_tag);
            taken.push_back(exp_tag);
        end else if (vexp) begin
            chk("head_tag", dequeue_phys_reg_tag, exp_q[0]);
        end
        if (rs) begin
            while (taken.size() > ckpt[rcol]) exp_q.push_front(taken.pop_back());
        end else if (sv) begin
            ckpt[scol] = taken.size();
        end
        if (enq && (pre < FREE_LIST_DEPTH || fire)) exp_q.push_back(etag);
        @(posedge CLK);
    endtask

    initial begin
        drive_idle();
        nRST = 1'b0;
        model_reset();

        // reset drain: 32..63 in order, then empty
        do_reset();
        repeat (32) step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // empty refill: no bypass, tag visible one cycle later
        step(1, 1, 5, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // enqueue while full is dropped
        do_reset();
        step(0, 1, 9, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // concurrent enqueue/dequeue at full across the wrap point
        repeat (40) step(1, 1, 7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // checkpoint restore with suppressed dequeue
        do_reset();
        step(0, 0, 0, 1, 2, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 0);

        // save coincident with a dequeue captures the advanced head
        step(1, 0, 0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // restore four tags back from empty while enqueueing 40
        do_reset();
        for (int i = 0; i < 32; i++) step(1, 0, 0, (i == 27), 0, 0, 0);
        step(0, 1, 40, 0, 0, 1, 0);
        repeat (5) step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // mid-operation reset also clears checkpoints
        do_reset();
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
